edge_driver: RTL and testbench
==============================

# edge_driver

Output-side counterpart to the input synchronizer/debouncer: it accepts `edges_t` requests from the control path and turns them into a clean, registered level on an output pin. Every output level is held for at least `MIN_HOLD_CYCLES` clocks, so downstream logic and external parts never see glitches or runt pulses. One pending request can be buffered while a hold is in progress. Each transition actually made on the pin is echoed back as an `edges_t` strobe.

## Interface
- `MIN_HOLD_CYCLES`, default 5: minimum number of clocks the output holds a level after any transition; legal range ≥ 1.
- `i_clk`  input  1  system clock.
- `i_reset_n`  input  1  asynchronous, active-low reset.
- `i_edges`  input  `edges_t`  request strobes, one cycle each:
  - `rising` = drive high.
  - `falling` = drive low.
  - Both set together = pulse: invert the current level, then restore it.
- `o_signal`  output  1  registered output level, intended for the pad.
- `o_edges`  output  `edges_t`  one-cycle echo, asserted in the same cycle `o_signal` takes a new value.
- `o_ready`  output  1  high when IDLE and nothing is pending; a request accepted now acts on the next clock.
- `o_overrun`  output  1  one-cycle pulse when a request replaces an occupied pending slot.

## Operation
- Reset values:
  - `o_signal` = 0.
  - `o_edges` = `RESET_VALUES_CONTROL_PATH`.
  - `o_ready` = 1.
  - `o_overrun` = 0.
  - state = IDLE, pending slot empty, hold counter = 0.
- States:
  - IDLE: no hold in progress.
  - HOLD: counter running after a transition.
- Request decode:
  - A level request whose target equals the current `o_signal`, with the pending slot empty, is a no-op: no echo, no state change.
  - A pulse always produces two transitions.
- IDLE plus an effective request:
  - `o_signal` toggles on the next edge, and the matching `o_edges` bit pulses in that cycle.
  - State goes to HOLD and the counter loads `MIN_HOLD_CYCLES-1`.
  - For a pulse, the pending slot is loaded internally with the original level; this does not count as an overrun.
- HOLD:
  - The counter decrements each cycle.
  - A new request is written into the pending slot as a target level (or pulse flag) and `o_ready` stays low.
  - If the slot was already occupied by an external request, the new request overwrites it (last wins) and `o_overrun` pulses.
- Hold expiry (counter = 0 in HOLD):
  - If pending is set and its target differs from `o_signal`: transition on the next edge, reload the counter, stay in HOLD. A pending pulse behaves like the IDLE pulse case.
  - Otherwise, clear pending and return to IDLE.
- A request arriving in the same cycle as hold expiry takes priority over the stored pending entry. The stored entry is discarded and `o_overrun` pulses.
- Asserting reset mid-hold or mid-pulse returns immediately to the reset values, including `o_signal` = 0. No completion of the pulse is attempted.
- Counter width is `$clog2(MIN_HOLD_CYCLES+1)`, unsigned, no wrap. Decrement happens only while the counter is nonzero.

## Timing
- Request sampled at edge n in IDLE: `o_signal` changes at edge n+1, `o_edges` is valid in cycle n+1.
- Consecutive transitions are separated by at least `MIN_HOLD_CYCLES` edges.
- A pulse from IDLE at edge n gives inverted level over edges n+1 … n+MIN_HOLD_CYCLES, and the level is restored at edge n+1+MIN_HOLD_CYCLES.
- `o_ready` rises in the cycle after the last hold expires with nothing pending.
- `MIN_HOLD_CYCLES` = 1 permits transitions on back-to-back edges. A pulse is then a one-cycle inversion.
- All outputs are registered. There is no combinational path from `i_edges` to any output.

## Structure
- `pipeline_types`:
  - Reuse the existing `edges_t` and `RESET_VALUES_CONTROL_PATH`.
  - Add `driver_state_t` (IDLE, HOLD) and the `pending_t` struct (valid, level, pulse, internal).
- One sub-module, `hold_timer`: load / decrement / expired flag, parameterised by `MIN_HOLD_CYCLES`.
- The top level holds the FSM, pending slot, output register and echo logic.

## Test plan
- Reset, then with `MIN_HOLD_CYCLES`=5, drive `rising` at cycle 10 → `o_signal`=1 from cycle 11, `o_edges.rising`=1 in cycle 11 only, `o_ready`=1 again at cycle 17.
- With `o_signal`=1, drive `falling` at cycle 12 (during hold) → falling edge at cycle 16, no overrun.
- With `o_signal`=0, drive a pulse (both bits) at cycle 20 → high over cycles 21–25, low at 26, one rising echo and one falling echo.
- During a hold, drive `falling` then `rising` → `o_overrun` pulses on the second request, and the final level follows the last request.
- With `o_signal`=0 and idle, drive `falling` → no echo, `o_ready` stays 1.
- Assert reset in the middle of a pulse → all outputs return to reset values in the same cycle, and the first request after release behaves as in the first scenario.

Source files
------------

// File: rtl/pipeline_types.sv
// Control-path types shared by the input conditioning and output drive blocks.
package pipeline_types;

    typedef struct packed {
        logic rising;
        logic falling;
    } edges_t;

    localparam edges_t RESET_VALUES_CONTROL_PATH = '{rising: 1'b0, falling: 1'b0};

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } driver_state_t;

    // internal marks the restore half of a pulse, which is not an overrun victim.
    typedef struct packed {
        logic valid;
        logic level;
        logic pulse;
        logic internal;
    } pending_t;

    localparam pending_t PENDING_EMPTY = '{valid: 1'b0, level: 1'b0, pulse: 1'b0, internal: 1'b0};

endpackage

// File: rtl/hold_timer.sv
// Minimum-hold down-counter: loads MIN_HOLD_CYCLES-1 on a transition and
// counts down to zero without wrapping; zero means the hold has expired.
module hold_timer #(
    parameter int MIN_HOLD_CYCLES = 5
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_load,
    output logic o_expired
);

    localparam int CW = $clog2(MIN_HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VALUE = CW'(MIN_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = LOAD_VALUE;
        end else if (count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == '0);

endmodule

// File: rtl/edge_driver.sv
// Turns rise/fall/pulse requests into a registered pad level that holds every
// value for at least MIN_HOLD_CYCLES clocks, with one buffered pending request.
module edge_driver
    import pipeline_types::*;
#(
    parameter int MIN_HOLD_CYCLES = 5
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  edges_t        i_edges,
    output logic          o_signal,
    output edges_t        o_edges,
    output logic          o_ready,
    output logic          o_overrun,
    output driver_state_t o_state
);

    driver_state_t state_q, state_d;
    pending_t      pend_q, pend_d;
    logic          signal_q, signal_d;
    edges_t        edges_q, edges_d;
    logic          ready_q, ready_d;
    logic          overrun_q, overrun_d;

    logic load;
    logic expired;
    logic req_valid, req_pulse, req_level;
    logic take, take_pulse, take_level, target;

    hold_timer #(
        .MIN_HOLD_CYCLES(MIN_HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (load),
        .o_expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        signal_d   = signal_q;
        edges_d    = RESET_VALUES_CONTROL_PATH;
        overrun_d  = 1'b0;
        load       = 1'b0;
        take       = 1'b0;
        take_pulse = 1'b0;
        take_level = 1'b0;
        req_valid  = i_edges.rising | i_edges.falling;
        req_pulse  = i_edges.rising & i_edges.falling;
        req_level  = i_edges.rising;

        case (state_q)
            IDLE: begin
                take       = req_valid;
                take_pulse = req_pulse;
                take_level = req_level;
            end
            HOLD: begin
                if (expired) begin
                    // A fresh request at expiry beats whatever is stored.
                    pend_d  = PENDING_EMPTY;
                    state_d = IDLE;
                    if (req_valid) begin
                        take       = 1'b1;
                        take_pulse = req_pulse;
                        take_level = req_level;
                        overrun_d  = pend_q.valid & ~pend_q.internal;
                    end else begin
                        take       = pend_q.valid;
                        take_pulse = pend_q.pulse;
                        take_level = pend_q.level;
                    end
                end else if (req_valid) begin
                    overrun_d = pend_q.valid & ~pend_q.internal;
                    pend_d    = '{valid: 1'b1, level: req_level, pulse: req_pulse, internal: 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        target = take_pulse ? ~signal_q : take_level;
        if (take && (target != signal_q)) begin
            signal_d        = target;
            edges_d.rising  = target;
            edges_d.falling = ~target;
            load            = 1'b1;
            state_d         = HOLD;
            if (take_pulse) begin
                pend_d = '{valid: 1'b1, level: signal_q, pulse: 1'b0, internal: 1'b1};
            end
        end

        ready_d = (state_q == IDLE) && !pend_q.valid && (state_d == IDLE) && !pend_d.valid;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            pend_q    <= PENDING_EMPTY;
            signal_q  <= 1'b0;
            edges_q   <= RESET_VALUES_CONTROL_PATH;
            ready_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            signal_q  <= signal_d;
            edges_q   <= edges_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_signal  = signal_q;
    assign o_edges   = edges_q;
    assign o_ready   = ready_q;
    assign o_overrun = overrun_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_edge_driver.sv
// Bench for edge_driver: a MIN_HOLD_CYCLES=5 unit driven from a cycle table,
// plus hand sequences for mid-pulse reset and a MIN_HOLD_CYCLES=1 unit.
module tb_edge_driver;
    import pipeline_types::*;

    localparam int W = 6;
    localparam edges_t NONE = '{rising: 1'b0, falling: 1'b0};
    localparam edges_t RISE = '{rising: 1'b1, falling: 1'b0};
    localparam edges_t FALL = '{rising: 1'b0, falling: 1'b1};
    localparam edges_t BOTH = '{rising: 1'b1, falling: 1'b1};

    typedef struct {
        edges_t     in;
        logic [4:0] exp;
    } vec_t;

    logic          clk;
    logic          rst_n;
    edges_t        edges0, edges1;
    logic          sig0, sig1, rdy0, rdy1, ov0, ov1;
    edges_t        oe0, oe1;
    driver_state_t st0, st1;

    logic [W-1:0] exp_q[$];
    vec_t         main_vec[$];
    int           total;
    int           bad;
    int           step_no;
    string        tag;

    edge_driver #(.MIN_HOLD_CYCLES(5)) u_dut5 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_edges   (edges0),
        .o_signal  (sig0),
        .o_edges   (oe0),
        .o_ready   (rdy0),
        .o_overrun (ov0),
        .o_state   (st0)
    );

    edge_driver #(.MIN_HOLD_CYCLES(1)) u_dut1 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_edges   (edges1),
        .o_signal  (sig1),
        .o_edges   (oe1),
        .o_ready   (rdy1),
        .o_overrun (ov1),
        .o_state   (st1)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Observed output vector: {signal, rising echo, falling echo, ready, overrun}
    function automatic logic [4:0] obs(input logic unit);
        if (unit) return {sig1, oe1.rising, oe1.falling, rdy1, ov1};
        return {sig0, oe0.rising, oe0.falling, rdy0, ov0};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got sig/r/f/rdy/ov=%b want %b", name, act, exp);
        end
    endtask

    task automatic pop_check();
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s@%0d", tag, step_no), obs(e[5]), e[4:0]);
        end
    endtask

    // Drive one request for the next edge and queue what the outputs must be after it.
    task automatic step(input logic unit, input edges_t e, input logic [4:0] exp);
        @(negedge clk);
        pop_check();
        edges0 = unit ? NONE : e;
        edges1 = unit ? e : NONE;
        exp_q.push_back({unit, exp});
        step_no++;
    endtask

    task automatic flush();
        @(negedge clk);
        pop_check();
        edges0 = NONE;
        edges1 = NONE;
    endtask

    task automatic add(input edges_t e, input logic [4:0] x);
        vec_t v;
        v.in  = e;
        v.exp = x;
        main_vec.push_back(v);
    endtask

    task automatic add_n(input edges_t e, input logic [4:0] x, input int n);
        for (int i = 0; i < n; i++) add(e, x);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        step_no = 0;
        tag     = "reset";
        rst_n   = 1'b0;
        edges0  = NONE;
        edges1  = NONE;

        // Expected outputs after each edge, MIN_HOLD_CYCLES = 5
        add(NONE, 5'b00010);
        add(FALL, 5'b00010);          // already low: no-op
        add(NONE, 5'b00010);
        add(RISE, 5'b11000);
        add(NONE, 5'b10000);
        add(FALL, 5'b10000);          // buffered during hold
        add_n(NONE, 5'b10000, 2);
        add(NONE, 5'b00100);          // buffered fall lands at expiry
        add_n(NONE, 5'b00000, 5);
        add(NONE, 5'b00010);
        add(BOTH, 5'b11000);          // pulse from low
        add_n(NONE, 5'b10000, 4);
        add(NONE, 5'b00100);          // pulse restore
        add(FALL, 5'b00000);
        add(RISE, 5'b00001);          // overwrite occupied slot
        add_n(NONE, 5'b00000, 2);
        add(NONE, 5'b11000);          // last request wins
        add(NONE, 5'b10000);
        add(RISE, 5'b10000);
        add_n(NONE, 5'b10000, 2);
        add(FALL, 5'b00101);          // request at expiry beats stored entry
        add_n(NONE, 5'b00000, 5);
        add(NONE, 5'b00010);
        add(RISE, 5'b11000);
        add(RISE, 5'b10000);          // stored target equals level
        add_n(NONE, 5'b10000, 4);
        add(NONE, 5'b10010);

        repeat (2) @(negedge clk);
        check("reset_u5", obs(1'b0), 5'b00010);
        check("reset_u1", obs(1'b1), 5'b00010);
        rst_n = 1'b1;

        tag = "table";
        for (int i = 0; i < main_vec.size(); i++) begin
            step(1'b0, main_vec[i].in, main_vec[i].exp);
        end
        flush();

        // Bring the level back low, then reset in the inverted half of a pulse.
        tag = "to_low";
        step(1'b0, FALL, 5'b00100);
        repeat (5) step(1'b0, NONE, 5'b00000);
        step(1'b0, NONE, 5'b00010);
        tag = "pulse_pre_reset";
        step(1'b0, BOTH, 5'b11000);
        step(1'b0, NONE, 5'b10000);
        flush();
        rst_n = 1'b0;
        #1;
        check("reset_mid_pulse", obs(1'b0), 5'b00010);
        @(negedge clk);
        check("reset_held", obs(1'b0), 5'b00010);
        rst_n = 1'b1;

        tag = "after_reset";
        step(1'b0, RISE, 5'b11000);
        repeat (5) step(1'b0, NONE, 5'b10000);
        step(1'b0, NONE, 5'b10010);
        flush();

        // MIN_HOLD_CYCLES = 1: back-to-back transitions
        tag = "hold1";
        step(1'b1, BOTH, 5'b11000);
        step(1'b1, NONE, 5'b00100);
        step(1'b1, NONE, 5'b00000);
        step(1'b1, NONE, 5'b00010);
        step(1'b1, RISE, 5'b11000);
        step(1'b1, FALL, 5'b00100);
        step(1'b1, NONE, 5'b00000);
        step(1'b1, NONE, 5'b00010);
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
